// File: rtl/delay_probe_meter_if.sv
// -----------------------------------------------------------------------------
// delay_probe_meter_if
//
// Bundles the probe/echo data path and the measurement status of
// delay_probe_meter. Clock and reset are not part of the bundle.
//
// Signals:
//   start      request a measurement (sampled by the meter in IDLE only)
//   marker     probe byte, captured when a start is accepted
//   echo_in    delay-line output read back by the meter
//   probe_out  registered drive into the delay-line data input
//   busy       measurement in progress (FLUSH, SEND, WAIT)
//   done       one-cycle completion pulse
//   timeout    one-cycle pulse alongside done when no echo was seen
//   lag        measured latency in cycles
//   valid      lag holds a successful measurement
//
// Modports:
//   master  the requester / delay-line side
//   slave   the meter itself
// -----------------------------------------------------------------------------
interface delay_probe_meter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] marker;
    logic [DATA_W-1:0] echo_in;
    logic [DATA_W-1:0] probe_out;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  lag;
    logic              valid;

    modport master (
        output start,
        output marker,
        output echo_in,
        input  probe_out,
        input  busy,
        input  done,
        input  timeout,
        input  lag,
        input  valid
    );

    modport slave (
        input  start,
        input  marker,
        input  echo_in,
        output probe_out,
        output busy,
        output done,
        output timeout,
        output lag,
        output valid
    );
endinterface

// File: rtl/delay_probe_meter.sv
// -----------------------------------------------------------------------------
// delay_probe_meter
//
// Measures the round-trip latency of a fixed-length delay line. On an accepted
// start it drives FLUSH_CYC zero cycles into the line, injects the captured
// marker for one cycle, then watches echo_in for the marker and reports the
// number of cycles it took to come back.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    delay_probe_meter_if.slave (start, marker, echo_in in;
//          probe_out, busy, done, timeout, lag, valid out)
//
// Parameters:
//   DATA_W     width of probe/echo data
//   CNT_W      width of the lag counter and lag output
//   MAX_LAG    last WAIT cycle checked before timeout (<= 2**CNT_W - 1)
//   FLUSH_CYC  zero cycles before the marker (>= longest line under test)
// -----------------------------------------------------------------------------
module delay_probe_meter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_LAG   = 200,
    parameter int unsigned FLUSH_CYC = 96
) (
    input  logic                 clk,
    input  logic                 rst_n,
    delay_probe_meter_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Flush phase has its own counter so FLUSH_CYC is not bounded by CNT_W.
    localparam int unsigned       FC_W       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0]   FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0]  LAG_LAST   = CNT_W'(MAX_LAG);

    logic [2:0]        state_q,   state_d;
    logic [FC_W-1:0]   fcnt_q,    fcnt_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] marker_q,  marker_d;
    logic [DATA_W-1:0] probe_q,   probe_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  lag_q,     lag_d;
    logic              valid_q,   valid_d;

    logic echo_match;

    // Exact match on every bit; only evaluated while in WAIT.
    assign echo_match = (bus.echo_in == marker_q);

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        cnt_d     = cnt_q;
        marker_d  = marker_q;
        probe_d   = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        lag_d     = lag_q;
        valid_d   = valid_q;

        unique case (state_q)
            S_IDLE: begin
                // A zero marker could never be told apart from the flush
                // pattern, so such a request is dropped without side effects.
                if (bus.start && (bus.marker != '0)) begin
                    marker_d = bus.marker;
                    valid_d  = 1'b0;
                    lag_d    = '0;
                    cnt_d    = '0;
                    fcnt_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = S_FLUSH;
                end
            end

            S_FLUSH: begin
                // probe_out is registered, so the marker is loaded on the
                // edge that enters SEND to be on the line during SEND.
                if (fcnt_q == FLUSH_LAST) begin
                    probe_d = marker_q;
                    state_d = S_SEND;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end

            S_SEND: begin
                cnt_d   = CNT_W'(1);
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (echo_match) begin
                    lag_d   = cnt_q;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == LAG_LAST) begin
                    lag_d     = '0;
                    valid_d   = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            fcnt_q    <= '0;
            cnt_q     <= '0;
            marker_q  <= '0;
            probe_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            lag_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            cnt_q     <= cnt_d;
            marker_q  <= marker_d;
            probe_q   <= probe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            lag_q     <= lag_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.probe_out = probe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.lag       = lag_q;
    assign bus.valid     = valid_q;

endmodule
